// File: rtl/traffic_conflict_monitor_if.sv
// Lamp bus between the light controller, the conflict monitor and the lamp drivers.
// The master drives controller codes and clear requests; the slave is the monitor.
interface traffic_conflict_monitor_if;
  logic [2:0] m1_in;
  logic [2:0] m2_in;
  logic [2:0] mt_in;
  logic [2:0] sr_in;
  logic       clr_fault;
  logic [2:0] m1_out;
  logic [2:0] m2_out;
  logic [2:0] mt_out;
  logic [2:0] sr_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [3:0] fault_src;

  modport master (
    output m1_in, m2_in, mt_in, sr_in, clr_fault,
    input  m1_out, m2_out, mt_out, sr_out, fault, fault_code, fault_src
  );

  modport slave (
    input  m1_in, m2_in, mt_in, sr_in, clr_fault,
    output m1_out, m2_out, mt_out, sr_out, fault, fault_code, fault_src
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Safety stage between the light controller and the lamp drivers: passes lamp codes through
// and latches a fail-safe red on illegal/conflicting/unsafe sequences. Flash: TRAFFIC_CONFLICT_MONITOR_FLASH_EN.
module traffic_conflict_monitor #(
  parameter int STARTUP_CYC = 4,
  parameter int GLITCH_CYC  = 2,
  parameter int MIN_YEL     = 3
`ifdef TRAFFIC_CONFLICT_MONITOR_FLASH_EN
  , parameter int FLASH_CYC = 8
`endif
) (
  input logic                         clk,
  input logic                         rst,
  traffic_conflict_monitor_if.slave   bus
);
  localparam logic [1:0] ST_STARTUP = 2'd0;
  localparam logic [1:0] ST_MONITOR = 2'd1;
  localparam logic [1:0] ST_FAULT   = 2'd2;

  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] RED = 3'b100;

  localparam int SW = $clog2(STARTUP_CYC + 1);
  localparam int GW = $clog2(GLITCH_CYC + 1);
  localparam int YW = $clog2(MIN_YEL + 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STARTUP_CYC - 1);
  localparam logic [GW-1:0] GL_LAST = GW'(GLITCH_CYC - 1);
  localparam logic [GW-1:0] GL_MAX  = GW'(GLITCH_CYC);
  localparam logic [YW-1:0] MIN_Y   = YW'(MIN_YEL);

  logic [1:0]    state_reg;
  logic [SW-1:0] st_cnt_reg;
  logic [GW-1:0] enc_cnt_reg, conf_cnt_reg;
  logic [YW-1:0] ycnt_reg  [4];
  logic [YW-1:0] ycnt_next [4];
  logic [2:0]    prev_reg  [4];
  logic [2:0]    out_reg   [4];
  logic [2:0]    lamp_in   [4];
  logic          fault_reg;
  logic [2:0]    code_reg, code_next;
  logic [3:0]    src_reg, src_next;
  logic [3:0]    is_r, perm, illegal, skip_src, short_src, conf_src;
  logic          enc_viol, conf_viol, enc_hit, conf_hit, fault_any, inputs_clean;
  logic [2:0]    fault_pat;

  // Lamp index order matches fault_src bits: 0 M1, 1 M2, 2 MT, 3 SR.
  assign lamp_in[0] = bus.m1_in;
  assign lamp_in[1] = bus.m2_in;
  assign lamp_in[2] = bus.mt_in;
  assign lamp_in[3] = bus.sr_in;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lamp
      assign is_r[gi]      = (lamp_in[gi] == RED);
      assign perm[gi]      = (lamp_in[gi] == GRN) || (lamp_in[gi] == YEL);
      assign illegal[gi]   = !(perm[gi] || is_r[gi]);
      assign skip_src[gi]  = (prev_reg[gi] == GRN) && is_r[gi];
      assign short_src[gi] = (prev_reg[gi] == YEL) && is_r[gi] && (ycnt_reg[gi] < MIN_Y);
      assign ycnt_next[gi] = (lamp_in[gi] != YEL) ? '0 :
                             (ycnt_reg[gi] == MIN_Y) ? ycnt_reg[gi] : ycnt_reg[gi] + YW'(1);
    end
  endgenerate

  // Only M1+M2 and M1+MT may be permissive together.
  assign conf_src[0] = perm[0] && perm[3];
  assign conf_src[1] = perm[1] && (perm[2] || perm[3]);
  assign conf_src[2] = perm[2] && (perm[1] || perm[3]);
  assign conf_src[3] = perm[3] && (perm[0] || perm[1] || perm[2]);

  assign enc_viol     = |illegal;
  assign conf_viol    = |conf_src;
  assign enc_hit      = enc_viol && (enc_cnt_reg >= GL_LAST);
  assign conf_hit     = conf_viol && (conf_cnt_reg >= GL_LAST);
  assign inputs_clean = !enc_viol && !conf_viol;

  always_comb begin
    code_next = 3'd0;
    src_next  = 4'd0;
    if (enc_hit) begin
      code_next = 3'd1;
      src_next  = illegal;
    end else if (conf_hit) begin
      code_next = 3'd2;
      src_next  = conf_src;
    end else if (|skip_src) begin
      code_next = 3'd3;
      src_next  = skip_src;
    end else if (|short_src) begin
      code_next = 3'd4;
      src_next  = short_src;
    end
  end

  assign fault_any = (code_next != 3'd0);

`ifdef TRAFFIC_CONFLICT_MONITOR_FLASH_EN
  localparam int FW = $clog2(FLASH_CYC + 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FLASH_CYC - 1);
  logic [FW-1:0] fl_cnt_reg;
  logic          fl_phase_reg;
  logic          fl_wrap;

  assign fl_wrap   = (fl_cnt_reg == FL_LAST);
  // The output register loads the phase that will be current after this edge.
  assign fault_pat = (fl_wrap ? ~fl_phase_reg : fl_phase_reg) ? 3'b000 : RED;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl_cnt_reg   <= '0;
      fl_phase_reg <= 1'b0;
    end else if (state_reg != ST_FAULT) begin
      fl_cnt_reg   <= '0;
      fl_phase_reg <= 1'b0;
    end else if (fl_wrap) begin
      fl_cnt_reg   <= '0;
      fl_phase_reg <= ~fl_phase_reg;
    end else begin
      fl_cnt_reg   <= fl_cnt_reg + FW'(1);
    end
  end
`else
  assign fault_pat = RED;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_STARTUP;
      st_cnt_reg   <= '0;
      enc_cnt_reg  <= '0;
      conf_cnt_reg <= '0;
      fault_reg    <= 1'b0;
      code_reg     <= 3'd0;
      src_reg      <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        ycnt_reg[i] <= '0;
        prev_reg[i] <= RED;
        out_reg[i]  <= RED;
      end
    end else begin
      case (state_reg)
        ST_STARTUP: begin
          for (int i = 0; i < 4; i++) begin
            prev_reg[i] <= lamp_in[i];
            out_reg[i]  <= RED;
          end
          if (st_cnt_reg == ST_LAST) begin
            st_cnt_reg <= '0;
            state_reg  <= ST_MONITOR;
          end else begin
            st_cnt_reg <= st_cnt_reg + SW'(1);
          end
        end
        ST_MONITOR: begin
          for (int i = 0; i < 4; i++) prev_reg[i] <= lamp_in[i];
          if (fault_any) begin
            state_reg <= ST_FAULT;
            fault_reg <= 1'b1;
            code_reg  <= code_next;
            src_reg   <= src_next;
            for (int i = 0; i < 4; i++) out_reg[i] <= RED;
          end else begin
            enc_cnt_reg  <= !enc_viol ? '0 : (enc_cnt_reg == GL_MAX) ? enc_cnt_reg : enc_cnt_reg + GW'(1);
            conf_cnt_reg <= !conf_viol ? '0 : (conf_cnt_reg == GL_MAX) ? conf_cnt_reg : conf_cnt_reg + GW'(1);
            for (int i = 0; i < 4; i++) begin
              ycnt_reg[i] <= ycnt_next[i];
              out_reg[i]  <= lamp_in[i];
            end
          end
        end
        default: begin
          for (int i = 0; i < 4; i++) out_reg[i] <= fault_pat;
          if (bus.clr_fault && inputs_clean) begin
            state_reg    <= ST_STARTUP;
            st_cnt_reg   <= '0;
            enc_cnt_reg  <= '0;
            conf_cnt_reg <= '0;
            fault_reg    <= 1'b0;
            code_reg     <= 3'd0;
            src_reg      <= 4'd0;
            for (int i = 0; i < 4; i++) begin
              ycnt_reg[i] <= '0;
              out_reg[i]  <= RED;
            end
          end
        end
      endcase
    end
  end

  assign bus.m1_out     = out_reg[0];
  assign bus.m2_out     = out_reg[1];
  assign bus.mt_out     = out_reg[2];
  assign bus.sr_out     = out_reg[3];
  assign bus.fault      = fault_reg;
  assign bus.fault_code = code_reg;
  assign bus.fault_src  = src_reg;
endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed vector bench for traffic_conflict_monitor: a table of per-cycle records plus
// hand-written fault-hold and reset sequences.
module tb_traffic_conflict_monitor;
  logic clk;
  logic rst;
  traffic_conflict_monitor_if bus();

  traffic_conflict_monitor dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] X = 3'b011;
  localparam logic [2:0] Z = 3'b111;

  typedef struct {
    logic [11:0] lamps;   // {m1, m2, mt, sr}
    logic        clr;
    logic [19:0] exp;     // {m1,m2,mt,sr outs, fault, code, src}
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [19:0] ex(input logic [11:0] o, input logic f,
                                     input logic [2:0] c, input logic [3:0] s);
    return {o, f, c, s};
  endfunction

  task automatic add(input logic [11:0] l, input logic c, input logic [19:0] e, input int n);
    vec_t v;
    v.lamps = l;
    v.clr   = c;
    v.exp   = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [19:0] e);
    logic [19:0] act;
    act = {bus.m1_out, bus.m2_out, bus.mt_out, bus.sr_out, bus.fault, bus.fault_code, bus.fault_src};
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got %b required %b", name, act, e);
    end else begin
      $display("ok   %s: %b", name, act);
    end
  endtask

  task automatic drive(input logic [11:0] l, input logic c);
    {bus.m1_in, bus.m2_in, bus.mt_in, bus.sr_in} = l;
    bus.clr_fault = c;
  endtask

  task automatic step(input logic [11:0] l, input logic c, input string name, input logic [19:0] e);
    drive(l, c);
    @(posedge clk);
    #1;
    check(name, e);
  endtask

  logic [19:0] allred;
  logic [2:0]  pat;

  initial begin
    allred = ex({R, R, R, R}, 1'b0, 3'd0, 4'd0);

    // startup ignores inputs
    add({G, G, R, R}, 0, allred, 4);
    // full controller cycle, pass-through with one cycle latency
    add({G, G, R, R}, 0, ex({G, G, R, R}, 0, 0, 0), 1);
    add({G, Y, R, R}, 0, ex({G, Y, R, R}, 0, 0, 0), 6);
    add({G, R, R, R}, 0, ex({G, R, R, R}, 0, 0, 0), 1);
    add({G, R, G, R}, 0, ex({G, R, G, R}, 0, 0, 0), 1);
    add({Y, R, Y, R}, 0, ex({Y, R, Y, R}, 0, 0, 0), 3);
    add({R, R, R, R}, 0, ex({R, R, R, R}, 0, 0, 0), 1);
    add({R, R, R, G}, 0, ex({R, R, R, G}, 0, 0, 0), 1);
    add({R, R, R, Y}, 0, ex({R, R, R, Y}, 0, 0, 0), 3);
    add({R, R, R, R}, 0, ex({R, R, R, R}, 0, 0, 0), 1);
    // one-cycle M2/MT conflict is filtered
    add({G, G, R, R}, 0, ex({G, G, R, R}, 0, 0, 0), 1);
    add({G, Y, R, R}, 0, ex({G, Y, R, R}, 0, 0, 0), 3);
    add({G, Y, G, R}, 0, ex({G, Y, G, R}, 0, 0, 0), 1);
    add({G, R, G, R}, 0, ex({G, R, G, R}, 0, 0, 0), 1);
    // two-cycle M2+MT green conflict faults on the second edge
    add({G, G, G, R}, 0, ex({G, G, G, R}, 0, 0, 0), 1);
    add({G, G, G, R}, 0, ex({R, R, R, R}, 1, 2, 4'b0110), 1);
    // clear refused with conflicting, then illegal inputs; accepted with legal ones
    add({G, G, G, R}, 1, ex({R, R, R, R}, 1, 2, 4'b0110), 1);
    add({X, R, R, R}, 1, ex({R, R, R, R}, 1, 2, 4'b0110), 1);
    add({R, R, R, R}, 1, allred, 1);
    add({G, G, R, R}, 0, allred, 4);
    add({G, G, R, R}, 0, ex({G, G, R, R}, 0, 0, 0), 1);
    // illegal SR encoding held two cycles
    add({G, G, R, X}, 0, ex({G, G, R, X}, 0, 0, 0), 1);
    add({G, G, R, X}, 0, ex({R, R, R, R}, 1, 1, 4'b1000), 1);
    add({G, G, R, R}, 1, allred, 1);
    add({G, G, R, R}, 0, allred, 4);
    add({G, G, R, R}, 0, ex({G, G, R, R}, 0, 0, 0), 1);
    // skipped yellow on M1
    add({R, G, R, R}, 0, ex({R, R, R, R}, 1, 3, 4'b0001), 1);
    add({R, R, R, R}, 1, allred, 1);
    add({R, R, R, R}, 0, allred, 4);
    // short yellow on M2
    add({R, G, R, R}, 0, ex({R, G, R, R}, 0, 0, 0), 1);
    add({R, Y, R, R}, 0, ex({R, Y, R, R}, 0, 0, 0), 2);
    add({R, R, R, R}, 0, ex({R, R, R, R}, 1, 4, 4'b0010), 1);
    add({R, R, R, R}, 1, allred, 1);
    add({G, G, R, R}, 0, allred, 4);
    // encoding and skipped yellow in the same cycle: lowest code wins
    add({G, G, R, Z}, 0, ex({G, G, R, Z}, 0, 0, 0), 1);
    add({R, G, R, Z}, 0, ex({R, R, R, R}, 1, 1, 4'b1000), 1);

    rst = 1'b1;
    drive({R, R, R, R}, 1'b0);
    #2;
    check("reset_state", allred);
    #10;
    rst = 1'b0;

    foreach (tbl[i]) step(tbl[i].lamps, tbl[i].clr, $sformatf("vec%0d", i), tbl[i].exp);

    // fault holds and ignores inputs; pattern depends on the flash build
    for (int k = 1; k <= 20; k++) begin
`ifdef TRAFFIC_CONFLICT_MONITOR_FLASH_EN
      pat = (((k / 8) % 2) == 1) ? 3'b000 : R;
`else
      pat = R;
`endif
      step({G, G, G, G}, 1'b0, $sformatf("fault_hold%0d", k), ex({pat, pat, pat, pat}, 1, 1, 4'b1000));
    end

    // asynchronous reset during FAULT, visible without a clock edge
    rst = 1'b1;
    #1;
    check("rst_in_fault", allred);
    #2;
    rst = 1'b0;
    step({G, G, R, R}, 0, "startup_a1", allred);
    step({G, G, R, R}, 0, "startup_a2", allred);

    // reset mid-STARTUP restarts the startup count
    rst = 1'b1;
    #1;
    check("rst_in_startup", allred);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) step({G, G, R, R}, 0, $sformatf("startup_b%0d", k), allred);
    step({G, G, R, R}, 0, "pass_after_rst", ex({G, G, R, R}, 0, 0, 0));
    // clr_fault in MONITOR has no effect
    step({G, G, R, R}, 1, "clr_in_monitor", ex({G, G, R, R}, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Downstream safety stage between the traffic light controller's four lamp outputs (M1, M2, MT, SR) and the lamp drivers.
- Registers and passes lamp codes through while checking them every cycle.
- Detects illegal encodings, conflicting permissive indications, skipped yellows and short yellows.
- On a fault, latches the fault and forces all lamps to a fail-safe red pattern until cleared.

Parameters:
- STARTUP_CYC, 4, cycles of forced all-red after reset before pass-through begins.
- GLITCH_CYC, 2, consecutive cycles an encoding/conflict violation must persist to fault (>=1).
- MIN_YEL, 3, minimum cycles a lamp must show yellow before red.
- FLASH_CYC, 8, half-period in cycles of the fault flash (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- m1_in  input  3  main road 1 lamp code from controller
- m2_in  input  3  main road 2 lamp code
- mt_in  input  3  main turn lamp code
- sr_in  input  3  side road lamp code
- clr_fault  input  1  single-cycle request to clear a latched fault
- m1_out  output  3  lamp code to M1 driver
- m2_out  output  3  lamp code to M2 driver
- mt_out  output  3  lamp code to MT driver
- sr_out  output  3  lamp code to SR driver
- fault  output  1  latched fault flag
- fault_code  output  3  0 none, 1 illegal encoding, 2 conflict, 3 skipped yellow, 4 short yellow
- fault_src  output  4  offending lamps: bit0 M1, bit1 M2, bit2 MT, bit3 SR

Behaviour:
- Lamp encoding: 3'b001 green, 3'b010 yellow, 3'b100 red. Any other value is illegal. Green or yellow is "permissive".
- Reset (async): state STARTUP, counters 0, all *_out = 3'b100, fault = 0, fault_code = 0, fault_src = 0.
- States:
  - STARTUP: outputs all red. After STARTUP_CYC cycles, go to MONITOR. Inputs are ignored and the previous-sample registers are loaded each cycle.
  - MONITOR: *_out <= *_in (1-cycle latency). Checks run every cycle.
  - FAULT: outputs forced (see Optional Feature). fault = 1.
- Allowed permissive pairs: M1+M2 and M1+MT only. Any other pair of simultaneous permissive lamps is a conflict; SR permissive with any other permissive lamp is a conflict.
- Encoding and conflict checks:
  - Each check has its own persistence counter, saturating at GLITCH_CYC.
  - The counter resets to 0 on any clean cycle.
  - Fault fires when the counter reaches GLITCH_CYC.
- Per-lamp yellow counter:
  - Increments while the input is yellow, saturating at MIN_YEL.
  - Clears on non-yellow.
  - A lamp held yellow for N cycles has count min(N, MIN_YEL) when it leaves yellow.
- Skipped yellow: previous sample green and current sample red. This faults immediately (no glitch filter).
- Short yellow: previous sample yellow, current sample red, and yellow count < MIN_YEL. Faults immediately.
- Fault entry:
  - On the cycle a fault qualifies, the registered outputs are forced to the FAULT pattern, and fault/fault_code/fault_src are set on the same clock edge. The violating code is never driven to the outputs.
  - If several faults qualify in one cycle, the lowest fault_code wins. fault_src is the union of the lamps implicated by that code only.
- In FAULT, checks are frozen and fault_code/fault_src hold.
- clr_fault:
  - Acted on only in FAULT, and only if the current inputs are legal and conflict-free.
  - When acted on: go to STARTUP and clear fault, fault_code, fault_src and all counters.
  - Otherwise it is ignored. clr_fault in STARTUP or MONITOR has no effect.
- rst mid-operation, in any state, returns immediately to the reset values above.

Optional Feature:
- Macro: TRAFFIC_CONFLICT_MONITOR_FLASH_EN.
- Defined: FAULT outputs alternate between all lamps 3'b100 and all lamps 3'b000. The phase toggles every FLASH_CYC cycles, and the first FLASH_CYC cycles of FAULT are red. The flash counter resets on FAULT entry.
- Undefined: FAULT outputs are steady 3'b100 on all lamps, and FLASH_CYC is unused.

Test Plan:
- Full controller cycle (M1/M2 green, M2 yellow 6 cycles, M1+MT green, etc.) after STARTUP -> outputs equal inputs delayed 1 cycle, fault stays 0.
- M2=001 and MT=001 for 1 cycle, then legal -> no fault. The same held 2 cycles -> fault=1, code=2, src=4'b0110, outputs all red on that edge.
- SR_in=3'b011 for 2 cycles -> code=1, src=4'b1000.
- M1 001 directly to 100 -> code=3, src=4'b0001 on the next edge. M2 yellow for 2 cycles then red -> code=4, src=4'b0010.
- In FAULT, pulse clr_fault with illegal inputs -> remains FAULT. Pulse with legal inputs -> STARTUP all red for 4 cycles, then pass-through, fault=0.
- Assert rst during FAULT (and separately mid-STARTUP) -> outputs 3'b100, fault=0 immediately. With the flash macro, FAULT shows red for 8 cycles, then 000 for 8 cycles, repeating.
